// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the lap timer controller: the controller state
// encoding and the display mux select codes.
// No ports; imported by lap_timer_ctrl and lap_ptr_ctrl.
// ---------------------------------------------------------------------------
package timer_pkg;

    // Controller states (Moore machine)
    typedef enum logic [2:0] {
        MODE_SELECT = 3'd0,
        CLEAR       = 3'd1,
        STOP_WATCH  = 3'd2,
        SAVE        = 3'd3,
        CYCLE       = 3'd4,
        INPUT       = 3'd5,
        TIMER       = 3'd6,
        TIME_UP     = 3'd7
    } state_t;

    // Display mux select codes
    localparam logic [1:0] SEL_MODE  = 2'b00;
    localparam logic [1:0] SEL_WATCH = 2'b01;
    localparam logic [1:0] SEL_LAPS  = 2'b10;
    localparam logic [1:0] SEL_TIMER = 2'b11;

endpackage

// File: rtl/lap_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// lap_ptr_ctrl
// Keeps track of the lap memory: where the next lap is written (wr_ptr),
// which stored lap is being displayed (rd_ptr) and how many slots hold a
// valid lap (lap_count, saturating at LAP_DEPTH).
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   save         store a lap this cycle (advance wr_ptr, bump lap_count)
//   cycle_enter  start browsing: point rd_ptr at the most recent lap
//   next         step rd_ptr to the previous stored lap
//   clr          start a new session: forget all stored laps
//   wr_ptr       next slot to write
//   rd_ptr       slot currently being read
//   lap_count    number of valid laps stored
// ---------------------------------------------------------------------------
module lap_ptr_ctrl
    import timer_pkg::*;
#(
    parameter int LAP_DEPTH = 4,
    parameter int PTR_W     = $clog2(LAP_DEPTH),
    parameter int CNT_W     = $clog2(LAP_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             save,
    input  logic             cycle_enter,
    input  logic             next,
    input  logic             clr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] lap_count
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(LAP_DEPTH);

    logic [PTR_W-1:0] last_slot;

    // Until the memory fills, laps occupy slots 0..lap_count-1, so the
    // oldest-to-newest wrap point is lap_count-1. Once full this equals
    // LAP_DEPTH-1, which is the natural modulo wrap.
    assign last_slot = PTR_W'(lap_count - CNT_W'(1));

    // Pointer and count registers. Browsing only steps when there is more
    // than one lap to step between.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lap_count <= '0;
        end else begin
            if (clr) begin
                wr_ptr    <= '0;
                lap_count <= '0;
            end else if (save) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (lap_count != FULL) begin
                    lap_count <= lap_count + CNT_W'(1);
                end
            end

            if (cycle_enter) begin
                rd_ptr <= (lap_count == '0) ? '0 : wr_ptr - PTR_W'(1);
            end else if (next && (lap_count > CNT_W'(1))) begin
                rd_ptr <= (rd_ptr == '0) ? last_slot : rd_ptr - PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/lap_timer_ctrl.sv
// ---------------------------------------------------------------------------
// lap_timer_ctrl
// Control unit for a stopwatch / lap memory / countdown timer. Sequences the
// datapath counter, the lap memory strobes, the display mux and the alarm.
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   pb0, pb1           debounced single-cycle button pulses
//   tick               1 Hz single-cycle enable
//   count_zero         datapath counter is zero
//   clear, enable, enable_increment, enable_decrement   counter controls
//   read, write, addr  lap memory strobes and address
//   output_select      display mux select
//   alarm              time-up indicator
// ---------------------------------------------------------------------------
module lap_timer_ctrl
    import timer_pkg::*;
#(
    parameter int LAP_DEPTH   = 4,
    parameter int ALARM_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb0,
    input  logic       pb1,
    input  logic       tick,
    input  logic       count_zero,
    output logic       clear,
    output logic       enable,
    output logic       enable_increment,
    output logic       enable_decrement,
    output logic       read,
    output logic       write,
    output logic [1:0] addr,
    output logic [1:0] output_select,
    output logic       alarm
);

    localparam int PTR_W = $clog2(LAP_DEPTH);
    localparam int CNT_W = $clog2(LAP_DEPTH + 1);
    localparam int ALM_W = $clog2(ALARM_TICKS + 1);

    state_t           state;
    state_t           next_state;
    logic [ALM_W-1:0] alarm_cnt;
    logic             alarm_done;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] lap_count;

    assign alarm_done = (alarm_cnt >= ALM_W'(ALARM_TICKS));

    lap_ptr_ctrl #(
        .LAP_DEPTH (LAP_DEPTH)
    ) u_lap_ptr (
        .clk         (clk),
        .rst         (rst),
        .save        (state == SAVE),
        .cycle_enter ((state == STOP_WATCH) && pb0),
        .next        ((state == CYCLE) && pb1 && !pb0),
        .clr         (state == CLEAR),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .lap_count   (lap_count)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MODE_SELECT;
        end else begin
            state <= next_state;
        end
    end

    // Alarm tick counter: held at zero outside TIME_UP so it always starts
    // from zero on entry, and stops once the limit is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_cnt <= '0;
        end else if (state != TIME_UP) begin
            alarm_cnt <= '0;
        end else if (tick && !alarm_done) begin
            alarm_cnt <= alarm_cnt + ALM_W'(1);
        end
    end

    // Next-state and output decode. Outputs are Moore except the counter
    // step enables, which pass the button/tick pulse straight through so
    // that each press or tick produces exactly one step.
    always_comb begin
        next_state       = state;
        clear            = 1'b0;
        enable           = 1'b0;
        enable_increment = 1'b0;
        enable_decrement = 1'b0;
        read             = 1'b0;
        write            = 1'b0;
        addr             = 2'b00;
        output_select    = SEL_MODE;
        alarm            = 1'b0;

        case (state)
            MODE_SELECT: begin
                clear         = 1'b1;
                output_select = SEL_MODE;
                if (pb0) begin
                    next_state = CLEAR;
                end else if (pb1) begin
                    next_state = INPUT;
                end
            end
            CLEAR: begin
                clear         = 1'b1;
                output_select = SEL_WATCH;
                next_state    = STOP_WATCH;
            end
            STOP_WATCH: begin
                enable        = 1'b1;
                output_select = SEL_WATCH;
                if (pb0) begin
                    next_state = CYCLE;
                end else if (pb1) begin
                    next_state = SAVE;
                end
            end
            SAVE: begin
                enable        = 1'b1;
                write         = 1'b1;
                addr          = 2'(wr_ptr);
                output_select = SEL_WATCH;
                next_state    = STOP_WATCH;
            end
            CYCLE: begin
                read          = 1'b1;
                addr          = 2'(rd_ptr);
                output_select = SEL_LAPS;
                if (pb0) begin
                    next_state = MODE_SELECT;
                end
            end
            INPUT: begin
                output_select    = SEL_TIMER;
                enable_increment = pb0;
                if (pb1 && !count_zero) begin
                    next_state = TIMER;
                end
            end
            TIMER: begin
                output_select    = SEL_TIMER;
                enable_decrement = tick;
                if (count_zero) begin
                    next_state = TIME_UP;
                end else if (pb0) begin
                    next_state = MODE_SELECT;
                end
            end
            TIME_UP: begin
                output_select = SEL_TIMER;
                alarm         = 1'b1;
                if (pb0 || alarm_done) begin
                    next_state = MODE_SELECT;
                end
            end
            default: begin
                next_state = MODE_SELECT;
            end
        endcase
    end

endmodule
